icache_sa: RTL
==============

// Module: icache_sa
// PURPOSE
//  Parametrised set-associative successor to the direct-mapped fetch cache; sits between fetch and the nibble-serial memory port.
//  Same fill protocol: one 4-bit nibble per wstrobe_d, high nibble of each byte first.
//  Adds: NWAYS=1/2 with per-set LRU, an explicit fill FSM with abort, per-line invalidate, RV=16/32 read width, async reset.
// PARAMETERS
//  LINE_LENGTH 4   bytes per line; power of 2, >=2, and >=RV/8
//  NSETS       4   sets; power of 2, >=1
//  NWAYS       2   ways per set; 1 or 2 only
//  RV          16  fetch width in bits; 16 or 32
//  PA          22  physical address width in bits
// PORTS
//  clk        in   1                        clock, all state updates on posedge
//  reset_n    in   1                        asynchronous, active-low reset
//  paddr      in   PA-1:1                   fetch address (byte numbering); held stable by fetch while pull=1
//  dread      in   4                        fill nibble
//  wstrobe_d  in   1                        dread valid this cycle
//  flush_all  in   1                        synchronous invalidate of every line; aborts any fill
//  inv_line   in   1                        synchronous invalidate of the way that hits paddr
//  hit        out  1                        paddr is resident; rdata valid
//  pull       out  1                        memory must stream a line for tag
//  tag        out  PA-1:$clog2(LINE_LENGTH) line address to fetch = paddr[PA-1:log2 LINE_LENGTH]
//  rdata      out  RV                       fetched halfword/word
// BEHAVIOUR
//  Addressing: set = paddr[log2(LL*NSETS)-1:log2 LL]; stored tag = paddr[PA-1:log2(LL*NSETS)].
//  Lookup is combinational, with zero-cycle latency. hit = some way in the set is valid with a matching tag, and state==IDLE.
//  rdata = the selected RV slice of the hitting line, indexed by paddr[log2 LL-1:log2(RV/8)]. rdata = 0 when hit=0.
//  pull = !hit and reset_n high. tag is always driven from paddr.
//  Reset (reset_n=0, takes effect immediately): all valid=0, LRU=0, state=IDLE, nibble count=0.
//   Outputs during reset: hit=0, pull=0, rdata=0. Data and tag arrays are not reset.
//  FSM IDLE: wstrobe_d with hit=0 -> select victim way, write nibble 0, count=1, go to FILL. wstrobe_d with hit=1 is ignored.
//  Victim selection: lowest-index invalid way; if none is invalid, the way given by lru[set]. NWAYS=1 -> always way 0.
//  FSM FILL: each wstrobe_d writes nibble k to nibble position k^1 of the victim line, then count+1.
//   Cycles without a strobe hold state.
//   Final nibble (k=2*LL-1): write tag, set valid, set lru[set] to the other way, count=0, go to IDLE.
//   hit rises on the following cycle.
//  LRU: a hit in IDLE on way w sets lru[set] = ~w. With 2 ways, a set filled twice evicts its least recently used way.
//  flush_all: clears all valid bits; in FILL also count=0 and go to IDLE. The partial line is discarded.
//   flush_all takes priority over fill completion and over inv_line in the same cycle.
//  inv_line: acts in IDLE only and clears valid of the hitting way. It does nothing on a miss or in FILL.
//  Fill completion and inv_line in the same cycle: inv_line is ignored, because it is ignored in FILL.
//  Changing paddr during FILL is a protocol violation. The victim set/way is not re-latched.
// TESTING
//  1 Reset, paddr=0x100, hit=0, pull=1, tag=0x40. Stream nibbles 1..8.
//    -> one cycle after the 8th strobe: hit=1, pull=0.
//    -> rdata=0x3412 at paddr[1]=0; rdata=0x7856 at paddr=0x102.
//  2 Fill 0x000 then 0x010 (same set, both ways) -> both hit.
//    Touch 0x000, then fill 0x020 -> 0x010 misses; 0x000 and 0x020 hit.
//  3 Assert flush_all after 3 nibbles of a fill -> hit=0, pull=1, state IDLE.
//    Re-streaming 8 nibbles gives correct rdata, with no stale nibbles.
//  4 With 0x000 and 0x010 resident, pulse inv_line at 0x010 -> next cycle 0x010 misses, 0x000 still hits.
//    inv_line on a missing address -> no change.
//  5 Drive reset_n low mid-fill, between clock edges -> hit=0 and pull=0 immediately.
//    After release: pull=1, and a full 8-nibble fill succeeds.
//  6 RV=32, LINE_LENGTH=8: stream bytes 0x11..0x88, high nibble first.
//    -> rdata=0x44332211 at paddr=0x0; rdata=0x88776655 at paddr=0x4.

Source files
------------

// File: rtl/icache_sa.sv
// Set-associative instruction fetch cache (1 or 2 ways) with a nibble-serial line fill.
// Lookup is combinational; a single FSM sequences fills, with abort and per-line invalidate.
module icache_sa #(
    parameter int LINE_LENGTH = 4,
    parameter int NSETS       = 4,
    parameter int NWAYS       = 2,
    parameter int RV          = 16,
    parameter int PA          = 22
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [PA-1:1]                    paddr,
    input  logic [3:0]                       dread,
    input  logic                             wstrobe_d,
    input  logic                             flush_all,
    input  logic                             inv_line,
    output logic                             hit,
    output logic                             pull,
    output logic [PA-1:$clog2(LINE_LENGTH)]  tag,
    output logic [RV-1:0]                    rdata
);

    localparam int OFFW   = $clog2(LINE_LENGTH);
    localparam int SETW   = $clog2(NSETS);
    localparam int SETI   = (SETW > 0) ? SETW : 1;
    localparam int TAGW   = PA - OFFW - SETW;
    localparam int LBITS  = LINE_LENGTH * 8;
    localparam int NNIB   = 2 * LINE_LENGTH;
    localparam int CNTW   = $clog2(NNIB);
    localparam int RSH    = $clog2(RV / 8);
    localparam int NWORDS = LBITS / RV;
    localparam int WSW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic              vway;
    logic [SETI-1:0]   vset;

    logic              valid [NWAYS][NSETS];
    logic [TAGW-1:0]   tags  [NWAYS][NSETS];
    logic [LBITS-1:0]  data  [NWAYS][NSETS];
    logic              lru   [NSETS];

    logic [PA-1:0]     addr;
    logic [SETI-1:0]   set_idx;
    logic [TAGW-1:0]   addr_tag;
    logic [WSW-1:0]    word_sel;
    logic [NWAYS-1:0]  way_hit;
    logic              hit_way;
    logic              victim;
    logic              start;
    logic              fstep;
    logic              wr_way;
    logic [SETI-1:0]   wr_set;
    logic [CNTW-1:0]   wr_pos;

    assign addr     = {paddr, 1'b0};
    assign addr_tag = addr[PA-1:OFFW+SETW];
    assign tag      = paddr[PA-1:OFFW];

    generate
        if (SETW > 0) begin : g_set
            assign set_idx = addr[OFFW+SETW-1:OFFW];
        end else begin : g_noset
            assign set_idx = '0;
        end
        if (NWORDS > 1) begin : g_word
            assign word_sel = addr[OFFW-1:RSH];
        end else begin : g_noword
            assign word_sel = '0;
        end
    endgenerate

    always_comb begin
        way_hit = '0;
        for (int unsigned w = 0; w < NWAYS; w++)
            way_hit[w] = valid[w][set_idx] && (tags[w][set_idx] == addr_tag);
        hit_way = (NWAYS == 2) && way_hit[NWAYS-1];
        hit     = (state == IDLE) && (|way_hit);
        pull    = !hit && reset_n;
        rdata   = hit ? data[hit_way][set_idx][word_sel*RV +: RV] : '0;
    end

    // Lowest invalid way first; with both ways valid fall back to the LRU way.
    always_comb begin
        victim = 1'b0;
        if (valid[0][set_idx])
            victim = ((NWAYS == 2) && !valid[NWAYS-1][set_idx]) ? 1'b1
                   : ((NWAYS == 2) ? lru[set_idx] : 1'b0);
    end

    always_comb begin
        start  = (state == IDLE) && wstrobe_d && !hit && !flush_all;
        fstep  = (state == FILL) && wstrobe_d && !flush_all;
        wr_way = start ? victim : vway;
        wr_set = start ? set_idx : vset;
        wr_pos = start ? CNTW'(1) : (cnt ^ CNTW'(1));
    end

    // Data and tag storage carry no reset.
    always_ff @(posedge clk) begin
        if (start || fstep)
            data[wr_way][wr_set][wr_pos*4 +: 4] <= dread;
        if (fstep && (cnt == CNTW'(NNIB-1)))
            tags[vway][vset] <= addr_tag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned w = 0; w < NWAYS; w++)
                for (int unsigned s = 0; s < NSETS; s++)
                    valid[w][s] <= 1'b0;
            for (int unsigned s = 0; s < NSETS; s++)
                lru[s] <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            vway  <= 1'b0;
            vset  <= '0;
        end else if (flush_all) begin
            for (int unsigned w = 0; w < NWAYS; w++)
                for (int unsigned s = 0; s < NSETS; s++)
                    valid[w][s] <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        lru[set_idx] <= ~hit_way;
                        if (inv_line)
                            valid[hit_way][set_idx] <= 1'b0;
                    end else if (wstrobe_d) begin
                        vway  <= victim;
                        vset  <= set_idx;
                        cnt   <= CNTW'(1);
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (wstrobe_d) begin
                        if (cnt == CNTW'(NNIB-1)) begin
                            valid[vway][vset] <= 1'b1;
                            lru[vset]         <= ~vway;
                            cnt               <= '0;
                            state             <= IDLE;
                        end else begin
                            cnt <= cnt + CNTW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
